// File: rtl/hdc_unary_bundler.sv
// Unary HDC encoder and bundler: per-sample thermometer compare of each
// feature channel against a shared level value, per-dimension accumulation
// across a bundle, and strict-majority thresholding to the bundled HV.
module hdc_unary_bundler #(
  parameter int unsigned DIM   = 64,
  parameter int unsigned VAL_W = 4,
  parameter int unsigned CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_last,
  input  logic [DIM*VAL_W-1:0] sob,
  input  logic [VAL_W-1:0]     hog,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DIM-1:0]       out_hv,
  output logic [CNT_W-1:0]     out_count,
  output logic                 out_sat
);

  localparam logic [CNT_W-1:0] N_MAX = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    S_ACC = 2'd0,
    S_FIN = 2'd1,
    S_OUT = 2'd2
  } state_t;

  state_t                      state;
  logic [DIM-1:0][CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]            n;
  logic                        sat;

  logic                        accept_c;
  logic [DIM-1:0]              hv_c;
  logic [DIM-1:0]              maj_c;

  assign accept_c = in_valid & in_ready;

  // Per-sample HV bit: feature strictly above level (same as thermometer test)
  always_comb begin
    hv_c = '0;
    for (int unsigned j = 0; j < DIM; j++) begin
      hv_c[j] = (sob[j*VAL_W +: VAL_W] > hog);
    end
  end

  // Strict majority at CNT_W+1 bits: 2*cnt > n, ties resolve to 0
  always_comb begin
    maj_c = '0;
    for (int unsigned j = 0; j < DIM; j++) begin
      maj_c[j] = ({cnt[j], 1'b0} > {1'b0, n});
    end
  end

  // Bundle FSM: accumulate, finalise for one cycle, hold output until taken
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_ACC;
      cnt       <= '0;
      n         <= '0;
      sat       <= 1'b0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out_hv    <= '0;
      out_count <= '0;
      out_sat   <= 1'b0;
    end else begin
      case (state)
        S_ACC: begin
          in_ready <= 1'b1;
          if (accept_c) begin
            // Once n is saturated, further samples are dropped but flagged
            if (n != N_MAX) begin
              for (int unsigned j = 0; j < DIM; j++) begin
                cnt[j] <= cnt[j] + CNT_W'(hv_c[j]);
              end
              n <= n + CNT_W'(1);
            end else begin
              sat <= 1'b1;
            end
            if (in_last) begin
              in_ready <= 1'b0;
              state    <= S_FIN;
            end
          end
        end
        S_FIN: begin
          out_hv    <= maj_c;
          out_count <= n;
          out_sat   <= sat;
          out_valid <= 1'b1;
          state     <= S_OUT;
        end
        S_OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            cnt       <= '0;
            n         <= '0;
            sat       <= 1'b0;
            in_ready  <= 1'b1;
            state     <= S_ACC;
          end
        end
        default: begin
          state <= S_ACC;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hdc_unary_bundler.sv
// Directed self-checking bench for hdc_unary_bundler (DIM=64, VAL_W=4, CNT_W=8).
module tb_hdc_unary_bundler;

  localparam int unsigned DIM   = 64;
  localparam int unsigned VAL_W = 4;
  localparam int unsigned CNT_W = 8;

  localparam logic [63:0] HV_RAMP = 64'hFF00FF00FF00FF00;
  localparam logic [63:0] HV_ONES = 64'hFFFFFFFFFFFFFFFF;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 in_valid;
  logic                 in_ready;
  logic                 in_last;
  logic [DIM*VAL_W-1:0] sob;
  logic [VAL_W-1:0]     hog;
  logic                 out_valid;
  logic                 out_ready;
  logic [DIM-1:0]       out_hv;
  logic [CNT_W-1:0]     out_count;
  logic                 out_sat;

  int tests_run = 0;
  int fail_cnt  = 0;

  hdc_unary_bundler #(.DIM(DIM), .VAL_W(VAL_W), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_last   (in_last),
    .sob       (sob),
    .hog       (hog),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_hv    (out_hv),
    .out_count (out_count),
    .out_sat   (out_sat)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    if (obs !== exp) begin
      fail_cnt++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [DIM*VAL_W-1:0] sob_ramp();
    logic [DIM*VAL_W-1:0] v;
    for (int j = 0; j < DIM; j++) v[j*VAL_W +: VAL_W] = VAL_W'(j % 16);
    return v;
  endfunction

  function automatic logic [DIM*VAL_W-1:0] sob_const(input logic [VAL_W-1:0] c);
    return {DIM{c}};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one sample and hold it until the block takes it
  task automatic send(input logic [DIM*VAL_W-1:0] s, input logic [VAL_W-1:0] h, input logic last);
    logic acc;
    int   budget;
    sob      = s;
    hog      = h;
    in_last  = last;
    in_valid = 1'b1;
    budget   = 0;
    do begin
      acc = in_ready;
      tick();
      budget++;
    end while (!acc && budget < 50);
    if (!acc) check("send_timeout", 64'(acc), 64'd1);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Wait for the bundled HV, check it, then complete the handshake
  task automatic take(input string tag, input logic [63:0] exp_hv, input logic [7:0] exp_cnt,
                      input logic exp_sat);
    int budget = 0;
    while (!out_valid && budget < 50) begin
      tick();
      budget++;
    end
    check({tag, "_valid"}, 64'(out_valid), 64'd1);
    check({tag, "_hv"},    64'(out_hv),    exp_hv);
    check({tag, "_count"}, 64'(out_count), 64'(exp_cnt));
    check({tag, "_sat"},   64'(out_sat),   64'(exp_sat));
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, "_drop"},  64'(out_valid), 64'd0);
    check({tag, "_rdy"},   64'(in_ready),  64'd1);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; sob = '0; hog = '0; out_ready = 1'b0;
    tick(); tick();
    check("rst_in_ready",  64'(in_ready),  64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_hv",    64'(out_hv),    64'd0);
    check("rst_out_count", 64'(out_count), 64'd0);
    check("rst_out_sat",   64'(out_sat),   64'd0);
    rst = 1'b0;
    #1;
    check("rst_rel_rdy0", 64'(in_ready), 64'd0);
    tick();
    check("rst_rel_rdy1", 64'(in_ready), 64'd1);

    // 1: ramp vs level 7, with latency check
    send(sob_ramp(), 4'd7, 1'b1);
    check("t1_lat_k",   64'(out_valid), 64'd0);
    check("t1_rdy_low", 64'(in_ready),  64'd0);
    tick();
    check("t1_lat_k1",  64'(out_valid), 64'd1);
    take("t1", HV_RAMP, 8'd1, 1'b0);

    // 2: single-sample boundaries
    send(sob_const(4'd15), 4'd0, 1'b1);  take("t2_max", HV_ONES, 8'd1, 1'b0);
    send(sob_const(4'd9),  4'd9, 1'b1);  take("t2_eq",  64'd0,   8'd1, 1'b0);
    send(sob_ramp(),       4'd15, 1'b1); take("t2_top", 64'd0,   8'd1, 1'b0);
    send(sob_const(4'd0),  4'd0, 1'b1);  take("t2_zero", 64'd0,  8'd1, 1'b0);

    // 3: three-sample majority
    send(sob_const(4'd15), 4'd0, 1'b0);
    send(sob_const(4'd0),  4'd0, 1'b0);
    send(sob_ramp(),       4'd7, 1'b1);
    take("t3", HV_RAMP, 8'd3, 1'b0);

    // 4: tie resolves to zero
    send(sob_const(4'd15), 4'd0, 1'b0);
    send(sob_const(4'd0),  4'd0, 1'b1);
    take("t4", 64'd0, 8'd2, 1'b0);

    // 5: backpressure with toggling in_valid
    send(sob_ramp(), 4'd7, 1'b1);
    tick();
    sob = sob_const(4'd15); hog = 4'd0; in_last = 1'b1;
    for (int c = 0; c < 5; c++) begin
      in_valid = (c % 2 == 0);
      tick();
      check("t5_valid", 64'(out_valid), 64'd1);
      check("t5_hv",    64'(out_hv),    HV_RAMP);
      check("t5_count", 64'(out_count), 64'd1);
      check("t5_rdy",   64'(in_ready),  64'd0);
    end
    in_valid = 1'b0; in_last = 1'b0;
    take("t5_out", HV_RAMP, 8'd1, 1'b0);
    send(sob_const(4'd15), 4'd0, 1'b1);
    take("t5_next", HV_ONES, 8'd1, 1'b0);

    // 6: saturation over 300 samples
    for (int i = 1; i <= 300; i++) send(sob_const(4'd15), 4'd0, i == 300);
    take("t6_sat", HV_ONES, 8'd255, 1'b1);

    // 6: reset in the middle of a bundle
    send(sob_const(4'd15), 4'd0, 1'b0);
    send(sob_const(4'd15), 4'd0, 1'b0);
    rst = 1'b1;
    #1;
    check("t6_rst_rdy",   64'(in_ready),  64'd0);
    check("t6_rst_hv",    64'(out_hv),    64'd0);
    check("t6_rst_count", 64'(out_count), 64'd0);
    check("t6_rst_sat",   64'(out_sat),   64'd0);
    check("t6_rst_valid", 64'(out_valid), 64'd0);
    tick();
    check("t6_rst_rdy2",  64'(in_ready),  64'd0);
    rst = 1'b0;
    tick();
    send(sob_ramp(), 4'd7, 1'b1);
    take("t6_post", HV_RAMP, 8'd1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests_run, fail_cnt);
    $finish;
  end

endmodule
